// File: rtl/tpu_pkg.sv
// Shared TPU definitions: unified-buffer geometry, address type and the
// state encoding of the unified-buffer read-back streamer.
package tpu_pkg;

  localparam int unsigned UB_DEPTH  = 64;
  localparam int unsigned UB_ADDR_W = 6;
  localparam int unsigned DATA_W    = 8;

  typedef logic [UB_ADDR_W-1:0] ub_addr_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    CAPTURE  = 3'd2,
    WAIT_LOW = 3'd3,
    PRESENT  = 3'd4,
    RELEASE  = 3'd5,
    FINISH   = 3'd6
  } stream_state_t;

endpackage : tpu_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous uio inputs; flops clear to 0 on reset.
//   clk   : destination clock
//   reset : asynchronous active-high reset
//   d     : asynchronous input
//   q     : input synchronized to clk (2-cycle latency)
module sync_2ff #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/ub_stream_out.sv
// Streams a contiguous window of the unified buffer to the host over the
// dedicated output pins using a four-phase req/ack handshake.
//   clk, reset          : system clock, asynchronous active-high reset
//   start               : begin transfer (sampled in IDLE only)
//   base_addr, length   : window start and word count (length clamps to DEPTH)
//   mem_rd_en/addr/data : unified-buffer read port (data one cycle after en)
//   out_data, out_valid : word and request to the host
//   out_ack             : host acknowledge, asynchronous to clk
//   busy, done          : transfer in progress / one-cycle completion pulse
module ub_stream_out #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ack,
  output logic              busy,
  output logic              done
);

  import tpu_pkg::*;

  localparam int unsigned LEN_W = ADDR_W + 1;

  stream_state_t     state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [LEN_W-1:0]  len_clamped_c;
  logic              ack_s;

  // Host acknowledge is only ever used after synchronization.
  sync_2ff #(.W(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (out_ack),
    .q     (ack_s)
  );

  // Requests longer than the buffer stream every entry exactly once.
  always_comb begin
    len_clamped_c = length;
    if (length > LEN_W'(DEPTH)) begin
      len_clamped_c = LEN_W'(DEPTH);
    end
  end

  // Transfer sequencer; every output is a register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= '0;
      remaining   <= '0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      done      <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            addr      <= base_addr;
            remaining <= len_clamped_c;
            busy      <= 1'b1;
            state     <= (len_clamped_c == '0) ? FINISH : READ;
          end
        end

        READ: begin
          mem_rd_en   <= 1'b1;
          mem_rd_addr <= addr;
          state       <= CAPTURE;
        end

        // The first CAPTURE cycle is the read-strobe cycle; data arrives on
        // the cycle after, so capture only once the strobe has dropped.
        CAPTURE: begin
          if (!mem_rd_en) begin
            out_data <= mem_rd_data;
            if (ack_s) begin
              state <= WAIT_LOW;
            end else begin
              out_valid <= 1'b1;
              state     <= PRESENT;
            end
          end
        end

        // A still-high acknowledge must fall before a new request is raised.
        WAIT_LOW: begin
          if (!ack_s) begin
            out_valid <= 1'b1;
            state     <= PRESENT;
          end
        end

        PRESENT: begin
          if (ack_s) begin
            out_valid <= 1'b0;
            addr      <= (addr == ADDR_W'(DEPTH - 1)) ? '0 : addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            state     <= RELEASE;
          end
        end

        RELEASE: begin
          if (!ack_s) begin
            state <= (remaining != '0) ? READ : FINISH;
          end
        end

        FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule : ub_stream_out

// File: tb/tb_ub_stream_out.sv
module tb_ub_stream_out;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [DATA_W-1:0] mem_rd_data;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ack;
  logic              busy;
  logic              done;

  ub_stream_out #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .length      (length),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ack     (out_ack),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Unified buffer: data valid the cycle after the strobe, garbage otherwise.
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    else           mem_rd_data <= DATA_W'($urandom);
  end

  // Reference model: the expected read addresses and words of the transfer.
  logic [ADDR_W-1:0] exp_addr[$];
  logic [DATA_W-1:0] exp_data[$];
  logic [ADDR_W-1:0] rd_log[$];
  logic [DATA_W-1:0] rx[$];
  int rd_idx = 0;
  int wd_idx = 0;
  int done_cnt = 0;
  bit active = 1'b0;

  // Host behaviour knobs.
  int unsigned dly_lo = 0;
  int unsigned dly_hi = 3;
  bit spurious = 1'b0;

  task automatic do_start(input int base, input int len);
    bit was_active;
    int n;
    @(negedge clk);
    was_active = active;
    start     = 1'b1;
    base_addr = ADDR_W'(base);
    length    = (ADDR_W+1)'(len);
    @(posedge clk);
    #1;
    if (!was_active) begin
      n = (len > int'(DEPTH)) ? int'(DEPTH) : len;
      exp_addr.delete(); exp_data.delete(); rd_log.delete(); rx.delete();
      for (int i = 0; i < n; i++) begin
        exp_addr.push_back(ADDR_W'((base + i) % DEPTH));
        exp_data.push_back(mem[(base + i) % DEPTH]);
      end
      rd_idx = 0;
      wd_idx = 0;
      active = 1'b1;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    int d0 = done_cnt;
    while (active && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("xfer_timeout", 32'(active), 32'd0);
    chk("done_count", done_cnt, d0 + 1);
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  // Compare process: checks outputs against the model every cycle.
  logic       prev_valid = 1'b0;
  logic       prev_done  = 1'b0;
  logic [3:0] ah = '0;
  logic [DATA_W-1:0] held = '0;
  always @(negedge clk) begin
    if (reset) begin
      prev_valid = 1'b0;
      prev_done  = 1'b0;
      ah         = '0;
    end else begin
      ah = {ah[2:0], out_ack};
      if (mem_rd_en) begin
        rd_log.push_back(mem_rd_addr);
        if (rd_idx < exp_addr.size()) chk("rd_addr", 32'(mem_rd_addr), 32'(exp_addr[rd_idx]));
        else                          chk("rd_extra", rd_idx, exp_addr.size());
        rd_idx++;
      end
      if (out_valid) begin
        if (wd_idx < exp_data.size()) chk("out_data", 32'(out_data), 32'(exp_data[wd_idx]));
        else                          chk("valid_extra", wd_idx, exp_data.size());
        // Acknowledge must have been low at the edge feeding the synchronizer.
        if (!prev_valid) chk("valid_rise_ack_low", 32'(ah[3]), 32'd0);
        else             chk("data_stable", 32'(out_data), 32'(held));
        held = out_data;
      end else if (prev_valid) begin
        wd_idx++;
      end
      if (done) begin
        chk("done_words", wd_idx, exp_data.size());
        chk("done_reads", rd_idx, exp_addr.size());
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_pulse", 32'(prev_done), 32'd0);
        chk("done_expected", 32'(active), 32'd1);
        done_cnt++;
        active = 1'b0;
      end else begin
        chk("busy_track", 32'(busy), 32'(active));
      end
      prev_valid = out_valid;
      prev_done  = done;
    end
  end

  // Four-phase host with randomized response times.
  initial begin
    out_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !reset) begin
        rx.push_back(out_data);
        repeat ($urandom_range(dly_hi, dly_lo)) @(posedge clk);
        @(posedge clk); #3 out_ack = 1'b1;
        do @(negedge clk); while (out_valid);
        repeat ($urandom_range(3, 0)) @(posedge clk);
        @(posedge clk); #3 out_ack = 1'b0;
        if (spurious) begin
          spurious = 1'b0;
          @(posedge clk); #3 out_ack = 1'b1;
          repeat (15) @(posedge clk);
          #3 out_ack = 1'b0;
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    int n;
    reset = 1'b1; start = 1'b0; base_addr = '0; length = '0;
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'($urandom);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 32'(mem_rd_en), 0);
    chk("rst_rd_addr", 32'(mem_rd_addr), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    reset = 1'b0;

    // Basic 4-word transfer with literal timing and data.
    mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
    do_start(0, 4);
    chk("t1_busy_e0", 32'(busy), 1);
    @(negedge clk);
    chk("t1_rd_en_e1", 32'(mem_rd_en), 1);
    chk("t1_rd_addr_e1", 32'(mem_rd_addr), 0);
    @(negedge clk);
    chk("t1_valid_e2", 32'(out_valid), 0);
    @(negedge clk);
    chk("t1_valid_e3", 32'(out_valid), 1);
    chk("t1_data_e3", 32'(out_data), 32'h11);
    wait_idle(2000);
    chk("t1_rx_n", rx.size(), 4);
    if (rx.size() == 4) begin
      chk("t1_rx0", 32'(rx[0]), 32'h11);
      chk("t1_rx1", 32'(rx[1]), 32'h22);
      chk("t1_rx2", 32'(rx[2]), 32'h33);
      chk("t1_rx3", 32'(rx[3]), 32'h44);
    end

    // Address wrap.
    do_start(62, 4);
    wait_idle(2000);
    chk("wrap_n", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("wrap_a0", 32'(rd_log[0]), 62);
      chk("wrap_a1", 32'(rd_log[1]), 63);
      chk("wrap_a2", 32'(rd_log[2]), 0);
      chk("wrap_a3", 32'(rd_log[3]), 1);
      chk("wrap_d2", 32'(rx[2]), 32'(mem[0]));
    end

    // Zero length.
    do_start(10, 0);
    chk("len0_busy", 32'(busy), 1);
    chk("len0_done_e0", 32'(done), 0);
    @(negedge clk);
    chk("len0_done_e1", 32'(done), 1);
    chk("len0_busy_e1", 32'(busy), 0);
    @(negedge clk);
    chk("len0_done_e2", 32'(done), 0);
    chk("len0_no_reads", rd_log.size(), 0);
    chk("len0_no_words", rx.size(), 0);

    // Oversized length clamps.
    do_start(17, 100);
    wait_idle(5000);
    chk("clamp_words", rx.size(), 64);
    chk("clamp_reads", rd_log.size(), 64);

    // Slow host plus acknowledge held high before the second word.
    dly_lo = 50; dly_hi = 50; spurious = 1'b1;
    do_start(5, 3);
    wait_idle(3000);
    chk("slow_words", rx.size(), 3);
    dly_lo = 0; dly_hi = 3; spurious = 1'b0;

    // Start while busy is ignored.
    do_start(20, 5);
    repeat (4) @(negedge clk);
    do_start(40, 5);
    wait_idle(3000);
    chk("ign_reads", rd_log.size(), 5);
    if (rd_log.size() == 5) chk("ign_first", 32'(rd_log[0]), 20);

    // Reset in the middle of word 2 of 5.
    dly_lo = 5; dly_hi = 10;
    do_start(30, 5);
    n = 0;
    while (!(wd_idx == 1 && out_valid) && n < 500) begin @(negedge clk); n++; end
    chk("mid_reach_word2", 32'(out_valid), 1);
    d0 = done_cnt;
    #2 reset = 1'b1;
    active = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(out_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_rd_en", 32'(mem_rd_en), 0);
    chk("mid_rst_data", 32'(out_data), 0);
    exp_addr.delete(); exp_data.delete();
    repeat (40) @(posedge clk);
    @(negedge clk);
    chk("mid_no_done", done_cnt, d0);
    reset = 1'b0;
    dly_lo = 0; dly_hi = 3;
    do_start(50, 3);
    wait_idle(2000);
    if (rd_log.size() > 0) chk("mid_restart_base", 32'(rd_log[0]), 50);
    chk("mid_restart_n", rd_log.size(), 3);

    // Randomized transfers.
    for (int t = 0; t < 6; t++) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = DATA_W'($urandom);
      dly_hi = $urandom_range(6, 0);
      do_start(int'($urandom_range(63, 0)), int'($urandom_range(100, 0)));
      wait_idle(6000);
      chk("rand_words", rx.size(), exp_data.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_ub_stream_out
